// File: rtl/reg_file_bank_if.sv
// Bus and hardware-update signal bundle for reg_file_bank.
// Parity_Err exists only when REG_FILE_PARITY_EN is defined.
interface reg_file_bank_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int NUM_OUT = 4
);

  // System controller side
  logic                      WrEn;
  logic                      RdEn;
  logic [ADDR_W-1:0]         Address;
  logic [DATA_W-1:0]         WrData;
  logic [DATA_W-1:0]         RdData;
  logic                      RdData_Valid;
  logic                      Access_Err;
`ifdef REG_FILE_PARITY_EN
  logic                      Parity_Err;
`endif

  // Status producers
  logic                      HW_WrEn;
  logic [ADDR_W-1:0]         HW_Address;
  logic [DATA_W-1:0]         HW_WrData;

  // Configuration fan-out
  logic [NUM_OUT*DATA_W-1:0] REG_OUT;

`ifdef REG_FILE_PARITY_EN
  modport master (
    output WrEn, RdEn, Address, WrData, HW_WrEn, HW_Address, HW_WrData,
    input  RdData, RdData_Valid, Access_Err, Parity_Err, REG_OUT
  );

  modport slave (
    input  WrEn, RdEn, Address, WrData, HW_WrEn, HW_Address, HW_WrData,
    output RdData, RdData_Valid, Access_Err, Parity_Err, REG_OUT
  );
`else
  modport master (
    output WrEn, RdEn, Address, WrData, HW_WrEn, HW_Address, HW_WrData,
    input  RdData, RdData_Valid, Access_Err, REG_OUT
  );

  modport slave (
    input  WrEn, RdEn, Address, WrData, HW_WrEn, HW_Address, HW_WrData,
    output RdData, RdData_Valid, Access_Err, REG_OUT
  );
`endif

endinterface

// File: rtl/reg_file_bank.sv
// Parametrised system register file: bus read/write port, hardware update port,
// access-error reporting, 1- or 2-cycle read latency. Optional macro: REG_FILE_PARITY_EN.
module reg_file_bank #(
  parameter int                      DATA_W   = 8,
  parameter int                      ADDR_W   = 4,
  parameter int                      DEPTH    = 16,
  parameter int                      NUM_OUT  = 4,
  parameter logic [DEPTH-1:0]        RO_MASK  = '0,
  parameter logic [DEPTH*DATA_W-1:0] RST_VALS = 128'h2081_0000,
  parameter int                      RD_LAT   = 1
) (
  input logic             CLK,
  input logic             RST,
  reg_file_bank_if.slave  bus
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic              err;
`ifdef REG_FILE_PARITY_EN
    logic              perr;
`endif
    logic [DATA_W-1:0] data;
  } rd_pkt_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef REG_FILE_PARITY_EN
  logic [DEPTH-1:0]  parity_q;
  logic              parity_err_q;
`endif

  logic              bus_in_range;
  logic              hw_in_range;
  logic              bus_ro;
  logic              bus_wr_ok;
  logic              bus_wr_err;
  logic              hw_wr_ok;
  logic              rd_ok;
  logic [IDX_W-1:0]  bus_idx;
  logic [IDX_W-1:0]  hw_idx;

  rd_pkt_t           rd_req_d;
  rd_pkt_t           rd_src;

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              access_err_q;

  // Request decode
  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    bus_idx      = bus.Address[IDX_W-1:0];
    hw_idx       = bus.HW_Address[IDX_W-1:0];
    bus_in_range = ({1'b0, bus.Address} < DEPTH_L);
    hw_in_range  = ({1'b0, bus.HW_Address} < DEPTH_L);
    bus_ro       = bus_in_range & RO_MASK[bus_idx];
    bus_wr_ok    = bus.WrEn & ~bus.RdEn & bus_in_range & ~bus_ro;
    bus_wr_err   = bus.WrEn & (bus.RdEn | ~bus_in_range | bus_ro);
    rd_ok        = bus.RdEn & ~bus.WrEn;
    hw_wr_ok     = bus.HW_WrEn & hw_in_range;
  end

  // Read sample taken at the request edge, so a same-cycle HW write is not seen
  always_comb begin
    rd_req_d       = '0;
    rd_req_d.valid = rd_ok;
    rd_req_d.err   = rd_ok & ~bus_in_range;
    if (rd_ok && bus_in_range) begin
      rd_req_d.data = mem_q[bus_idx];
`ifdef REG_FILE_PARITY_EN
      rd_req_d.perr = (^mem_q[bus_idx]) ^ parity_q[bus_idx];
`endif
    end
  end

  // Storage
  // NOTE: the storage array is reset on purpose: every entry must come up holding its RST_VALS image.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_VALS[i*DATA_W +: DATA_W];
      end
    end else begin
      if (hw_wr_ok) begin
        mem_q[hw_idx] <= bus.HW_WrData;
      end
      // NOTE: sequential state uses '<='; the last assignment to an entry wins, which gives the bus write priority.
      if (bus_wr_ok) begin
        mem_q[bus_idx] <= bus.WrData;
      end
    end
  end

`ifdef REG_FILE_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        parity_q[i] <= ^RST_VALS[i*DATA_W +: DATA_W];
      end
    end else begin
      if (hw_wr_ok) begin
        parity_q[hw_idx] <= ^bus.HW_WrData;
      end
      if (bus_wr_ok) begin
        parity_q[bus_idx] <= ^bus.WrData;
      end
    end
  end
`endif

  // Optional extra read stage; flushed by reset so an in-flight read never completes
  if (RD_LAT == 2) begin : g_lat2
    rd_pkt_t pipe_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= rd_req_d;
      end
    end

    assign rd_src = pipe_q;
  end else begin : g_lat1
    assign rd_src = rd_req_d;
  end

  // Output stage: pulses last one cycle, read data holds between valids
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      rd_valid_q   <= rd_src.valid;
      access_err_q <= bus_wr_err | rd_src.err;
      if (rd_src.valid) begin
        rd_data_q <= rd_src.data;
      end
    end
  end

`ifdef REG_FILE_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= rd_src.valid & rd_src.perr;
    end
  end

  assign bus.Parity_Err = parity_err_q;
`endif

  assign bus.RdData       = rd_data_q;
  assign bus.RdData_Valid = rd_valid_q;
  assign bus.Access_Err   = access_err_q;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_reg_out
    assign bus.REG_OUT[i*DATA_W +: DATA_W] = mem_q[i];
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed bench for reg_file_bank: instance A (DEPTH 16, entry 2 read-only, RD_LAT 1)
// and instance B (DEPTH 12, RD_LAT 2) share clock and reset.
module tb_reg_file_bank;

  logic CLK;
  logic RST;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_bank_if #(.DATA_W(8), .ADDR_W(4), .NUM_OUT(4)) a_if ();
  reg_file_bank_if #(.DATA_W(8), .ADDR_W(4), .NUM_OUT(4)) b_if ();

  reg_file_bank #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(16), .NUM_OUT(4),
    .RO_MASK(16'h0004), .RST_VALS(128'h2081_0000), .RD_LAT(1)
  ) u_a (
    .CLK (CLK),
    .RST (RST),
    .bus (a_if.slave)
  );

  reg_file_bank #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(12), .NUM_OUT(4),
    .RO_MASK(12'h000), .RST_VALS(96'h2081_0000), .RD_LAT(2)
  ) u_b (
    .CLK (CLK),
    .RST (RST),
    .bus (b_if.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all();
    a_if.WrEn = 1'b0; a_if.RdEn = 1'b0; a_if.Address = '0; a_if.WrData = '0;
    a_if.HW_WrEn = 1'b0; a_if.HW_Address = '0; a_if.HW_WrData = '0;
    b_if.WrEn = 1'b0; b_if.RdEn = 1'b0; b_if.Address = '0; b_if.WrData = '0;
    b_if.HW_WrEn = 1'b0; b_if.HW_Address = '0; b_if.HW_WrData = '0;
  endtask

  logic [7:0] rst_img [16];

  initial begin
    for (int i = 0; i < 16; i++) rst_img[i] = 8'h00;
    rst_img[2] = 8'h81;
    rst_img[3] = 8'h20;

    idle_all();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;

    // Reset state on both instances
    check("a_rst_rddata", 64'(a_if.RdData), 64'h00);
    check("a_rst_valid",  64'(a_if.RdData_Valid), 64'h0);
    check("a_rst_err",    64'(a_if.Access_Err), 64'h0);
    check("a_rst_regout", 64'(a_if.REG_OUT), 64'h2081_0000);
    check("b_rst_regout", 64'(b_if.REG_OUT), 64'h2081_0000);
    check("b_rst_valid",  64'(b_if.RdData_Valid), 64'h0);

    // Read every address of A after reset
    for (int i = 0; i < 16; i++) begin
      a_if.RdEn = 1'b1;
      a_if.Address = 4'(i);
      step();
      check($sformatf("a_rst_read%0d_valid", i), 64'(a_if.RdData_Valid), 64'h1);
      check($sformatf("a_rst_read%0d_data", i), 64'(a_if.RdData), 64'(rst_img[i]));
      check($sformatf("a_rst_read%0d_err", i), 64'(a_if.Access_Err), 64'h0);
`ifdef REG_FILE_PARITY_EN
      check($sformatf("a_rst_read%0d_perr", i), 64'(a_if.Parity_Err), 64'h0);
`endif
    end
    a_if.RdEn = 1'b0;
    step();
    check("a_read_end_valid", 64'(a_if.RdData_Valid), 64'h0);

    // Bus write then read back
    a_if.WrEn = 1'b1; a_if.Address = 4'd1; a_if.WrData = 8'h5A;
    step();
    a_if.WrEn = 1'b0;
    check("a_wr1_regout", 64'(a_if.REG_OUT[15:8]), 64'h5A);
    check("a_wr1_err",    64'(a_if.Access_Err), 64'h0);
    check("a_wr1_valid",  64'(a_if.RdData_Valid), 64'h0);
    a_if.RdEn = 1'b1; a_if.Address = 4'd1;
    step();
    a_if.RdEn = 1'b0;
    check("a_rd1_valid", 64'(a_if.RdData_Valid), 64'h1);
    check("a_rd1_data",  64'(a_if.RdData), 64'h5A);
    step();
    check("a_rd1_pulse", 64'(a_if.RdData_Valid), 64'h0);
    check("a_rd1_hold",  64'(a_if.RdData), 64'h5A);

    // Bus write to the read-only entry
    a_if.WrEn = 1'b1; a_if.Address = 4'd2; a_if.WrData = 8'hFF;
    step();
    a_if.WrEn = 1'b0;
    check("a_ro_err",    64'(a_if.Access_Err), 64'h1);
    check("a_ro_regout", 64'(a_if.REG_OUT[23:16]), 64'h81);
    step();
    check("a_ro_err_pulse", 64'(a_if.Access_Err), 64'h0);

    // HW write ignores the read-only mask
    a_if.HW_WrEn = 1'b1; a_if.HW_Address = 4'd2; a_if.HW_WrData = 8'h33;
    step();
    a_if.HW_WrEn = 1'b0;
    check("a_hw_regout", 64'(a_if.REG_OUT[23:16]), 64'h33);
    check("a_hw_err",    64'(a_if.Access_Err), 64'h0);
    a_if.RdEn = 1'b1; a_if.Address = 4'd2;
    step();
    a_if.RdEn = 1'b0;
    check("a_hw_rd_data", 64'(a_if.RdData), 64'h33);

    // Simultaneous write and read request
    a_if.WrEn = 1'b1; a_if.RdEn = 1'b1; a_if.Address = 4'd3; a_if.WrData = 8'h99;
    step();
    a_if.WrEn = 1'b0; a_if.RdEn = 1'b0;
    check("a_both_err",    64'(a_if.Access_Err), 64'h1);
    check("a_both_valid",  64'(a_if.RdData_Valid), 64'h0);
    check("a_both_regout", 64'(a_if.REG_OUT[31:24]), 64'h20);
    step();
    check("a_both_err_pulse", 64'(a_if.Access_Err), 64'h0);

    // Bus and HW write to the same entry: bus wins
    a_if.WrEn = 1'b1; a_if.Address = 4'd5; a_if.WrData = 8'h11;
    a_if.HW_WrEn = 1'b1; a_if.HW_Address = 4'd5; a_if.HW_WrData = 8'h22;
    step();
    a_if.WrEn = 1'b0; a_if.HW_WrEn = 1'b0;
    a_if.RdEn = 1'b1; a_if.Address = 4'd5;
    step();
    a_if.RdEn = 1'b0;
    check("a_coll_data", 64'(a_if.RdData), 64'h11);

    // Bus and HW write to different entries: both land
    a_if.WrEn = 1'b1; a_if.Address = 4'd0; a_if.WrData = 8'h44;
    a_if.HW_WrEn = 1'b1; a_if.HW_Address = 4'd1; a_if.HW_WrData = 8'h66;
    step();
    a_if.WrEn = 1'b0; a_if.HW_WrEn = 1'b0;
    check("a_dual_regout", 64'(a_if.REG_OUT[15:0]), 64'h6644);

    // HW write during a bus read of the same entry: old value returned
    a_if.RdEn = 1'b1; a_if.Address = 4'd3;
    a_if.HW_WrEn = 1'b1; a_if.HW_Address = 4'd3; a_if.HW_WrData = 8'h77;
    step();
    a_if.RdEn = 1'b0; a_if.HW_WrEn = 1'b0;
    check("a_rdhw_data",   64'(a_if.RdData), 64'h20);
    check("a_rdhw_valid",  64'(a_if.RdData_Valid), 64'h1);
    check("a_rdhw_regout", 64'(a_if.REG_OUT[31:24]), 64'h77);

    // B: back-to-back reads with two-cycle latency
    b_if.RdEn = 1'b1; b_if.Address = 4'd2;
    step();
    check("b_pipe_c1_valid", 64'(b_if.RdData_Valid), 64'h0);
    b_if.Address = 4'd3;
    step();
    b_if.RdEn = 1'b0;
    check("b_pipe_c2_valid", 64'(b_if.RdData_Valid), 64'h1);
    check("b_pipe_c2_data",  64'(b_if.RdData), 64'h81);
    step();
    check("b_pipe_c3_valid", 64'(b_if.RdData_Valid), 64'h1);
    check("b_pipe_c3_data",  64'(b_if.RdData), 64'h20);
    step();
    check("b_pipe_c4_valid", 64'(b_if.RdData_Valid), 64'h0);
    check("b_pipe_c4_hold",  64'(b_if.RdData), 64'h20);

    // B: read beyond DEPTH returns zero with an error on the valid cycle
    b_if.RdEn = 1'b1; b_if.Address = 4'd14;
    step();
    b_if.RdEn = 1'b0;
    check("b_oor_c1_valid", 64'(b_if.RdData_Valid), 64'h0);
    check("b_oor_c1_err",   64'(b_if.Access_Err), 64'h0);
    step();
    check("b_oor_c2_valid", 64'(b_if.RdData_Valid), 64'h1);
    check("b_oor_c2_data",  64'(b_if.RdData), 64'h00);
    check("b_oor_c2_err",   64'(b_if.Access_Err), 64'h1);
    step();
    check("b_oor_c3_valid", 64'(b_if.RdData_Valid), 64'h0);
    check("b_oor_c3_err",   64'(b_if.Access_Err), 64'h0);

    // B: HW write beyond DEPTH is dropped silently
    b_if.HW_WrEn = 1'b1; b_if.HW_Address = 4'd14; b_if.HW_WrData = 8'h55;
    step();
    b_if.HW_WrEn = 1'b0;
    check("b_hw_oor_err",    64'(b_if.Access_Err), 64'h0);
    check("b_hw_oor_regout", 64'(b_if.REG_OUT), 64'h2081_0000);

    // B: complete a read so RdData is nonzero before the reset-flush case
    b_if.RdEn = 1'b1; b_if.Address = 4'd2;
    step();
    b_if.RdEn = 1'b0;
    step();
    check("b_pre_rst_data", 64'(b_if.RdData), 64'h81);

    // B: read in flight when reset asserts never completes
    b_if.RdEn = 1'b1; b_if.Address = 4'd2;
    step();
    b_if.RdEn = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("b_flush_valid", 64'(b_if.RdData_Valid), 64'h0);
    check("b_flush_data",  64'(b_if.RdData), 64'h00);
    check("b_flush_err",   64'(b_if.Access_Err), 64'h0);
    check("a_rerst_regout", 64'(a_if.REG_OUT), 64'h2081_0000);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("b_flush_after%0d_valid", i), 64'(b_if.RdData_Valid), 64'h0);
      check($sformatf("b_flush_after%0d_data", i),  64'(b_if.RdData), 64'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_bank.md
Name: reg_file_bank

Overview:
- Parametrised successor of the 8x16 system register file. Bus-side read/write port for the system controller, plus a hardware update port so status producers (ALU flags, UART error counters) can write without going through the controller.
- Configurable depth, width, number of exposed configuration registers, read-only mask, reset image and read latency.
- Access errors are reported instead of dropped silently.
- Sits in the system clock domain between the system controller and the ALU/UART/clock-divider configuration inputs.

Parameters:
- DATA_W, 8, entry width in bits.
- ADDR_W, 4, address width.
- DEPTH, 16, number of entries; must be ≤ 2^ADDR_W.
- NUM_OUT, 4, entries 0..NUM_OUT-1 driven continuously on REG_OUT.
- RO_MASK, 16'h0000, DEPTH bits; bit i = 1 makes entry i read-only from the bus port.
- RST_VALS, 128'h2081_0000, DEPTH*DATA_W bits; entry i reset value = RST_VALS[i*DATA_W +: DATA_W]. Default gives entry2 = 0x81, entry3 = 0x20, all others 0.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- WrEn  in  1  bus write request.
- RdEn  in  1  bus read request.
- Address  in  ADDR_W  bus address.
- WrData  in  DATA_W  bus write data.
- RdData  out  DATA_W  read data.
- RdData_Valid  out  1  one-cycle pulse marking RdData.
- Access_Err  out  1  one-cycle error pulse.
- HW_WrEn  in  1  hardware update strobe.
- HW_Address  in  ADDR_W  hardware update address.
- HW_WrData  in  DATA_W  hardware update data.
- REG_OUT  out  NUM_OUT*DATA_W  entry i at bits [i*DATA_W +: DATA_W].

Behaviour:
- Clocking/reset: one clock (CLK). Reset RST is synchronous and active-high.
- While RST=1 at a rising edge:
  - every entry loads its RST_VALS slice;
  - RdData=0, RdData_Valid=0, Access_Err=0;
  - the read pipeline is flushed, so a read in flight when reset asserts never produces a valid.
- Bus cycle decode, per rising edge with RST=0:
  - WrEn=1, RdEn=0, Address<DEPTH, RO_MASK[Address]=0: entry updated with WrData; visible on REG_OUT and to reads from the next cycle.
  - WrEn=1, RdEn=0, and either Address≥DEPTH or entry read-only: no update; Access_Err=1 next cycle.
  - RdEn=1, WrEn=0, Address<DEPTH: the entry value sampled at this edge appears on RdData with RdData_Valid=1 exactly RD_LAT cycles later.
  - RdEn=1, WrEn=0, Address≥DEPTH: RdData=0 with RdData_Valid=1 after RD_LAT cycles; Access_Err=1 in the same cycle as that valid.
  - WrEn=1 and RdEn=1: neither operation performed; Access_Err=1 next cycle; no valid.
- Pulses and hold:
  - RdData_Valid and Access_Err are single-cycle pulses.
  - RdData holds its last value when no valid is issued.
- Back-to-back reads:
  - Reads may be issued every cycle.
  - With RD_LAT=2 the pipeline holds two reads in flight; results come out in issue order, one per cycle.
- Hardware port:
  - HW_WrEn=1 and HW_Address<DEPTH: entry updated regardless of RO_MASK.
  - HW_Address≥DEPTH: ignored; no error reported.
- Collisions:
  - Bus write and HW write to the same entry in the same cycle: the bus write wins and the HW data is lost.
  - Different entries: both writes happen.
  - HW write in the same cycle as a bus read of that entry: the read returns the old value.
- REG_OUT: continuously reflects the current register contents; no added latency beyond the write edge.

Optional Feature:
- Macro: REG_FILE_PARITY_EN.
- When defined:
  - each entry stores an extra even-parity bit, computed on every write (bus, HW and reset load);
  - a read recomputes parity of the stored data;
  - on mismatch, output Parity_Err (1 bit, reset 0) pulses together with RdData_Valid;
  - RdData still returns the stored data.
- When undefined: no parity storage, no Parity_Err port; behaviour otherwise identical.

Test Plan:
- Reset then read addresses 0..15 (RD_LAT=1) -> RdData 0x00,0x00,0x81,0x20,0x00…; one valid per read, one cycle after each RdEn; REG_OUT = 0x2081_0000.
- Write 0x5A to addr 1, read addr 1 on the next cycle -> RdData=0x5A, valid 1 cycle later; REG_OUT[15:8]=0x5A from the cycle after the write.
- RO_MASK=16'h0004: bus write 0xFF to addr 2 -> Access_Err pulse, entry stays 0x81. Then HW write 0x33 to addr 2 -> read returns 0x33.
- WrEn=RdEn=1 at addr 3 -> Access_Err pulse, no RdData_Valid, entry 3 stays 0x20. DEPTH=12 with a read at addr 14 -> RdData=0, valid and Access_Err pulse together.
- Same cycle: bus write 0x11 and HW write 0x22 to addr 5 -> entry 5 = 0x11. RD_LAT=2 with reads issued on consecutive cycles at addr 2, 3 -> valids on cycles +2 and +3 with 0x81 then 0x20.
- Read addr 2 with RD_LAT=2 and RST asserted one cycle later -> no RdData_Valid ever; all outputs 0.
